// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the multi-channel SAR sequencer.
//   sar_state_e : sequencer FSM states
//   clog2_min1  : width helper, ceil(log2(n)) but never below one bit
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_ACC,
    ST_NEXT
  } sar_state_e;

  // A select or counter for n distinct values; a single value still gets a
  // one-bit field so no port or register collapses to zero width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_seq_mc_if.sv
// sar_seq_mc_if: analog-front-end and result bus of the SAR sequencer.
//   start, cont, ch_mask : scan control, driven by the host
//   cmp                  : comparator result, 1 means Vin > Vdac
//   dac_n                : active-low DAC trial word
//   ch_sel, sample       : analog mux select and S/H track enable
//   busy, data, data_ch, done : status and averaged result with its channel
// Modport slave is the sequencer side, master is the host/analog side.
interface sar_seq_mc_if #(
  parameter int SIZE = 8,
  parameter int NCH  = 4
);
  import sar_pkg::*;

  localparam int CHW = clog2_min1(NCH);

  logic            start;
  logic            cont;
  logic [NCH-1:0]  ch_mask;
  logic            cmp;
  logic [SIZE-1:0] dac_n;
  logic [CHW-1:0]  ch_sel;
  logic            sample;
  logic            busy;
  logic [SIZE-1:0] data;
  logic [CHW-1:0]  data_ch;
  logic            done;

  modport slave (
    input  start, cont, ch_mask, cmp,
    output dac_n, ch_sel, sample, busy, data, data_ch, done
  );

  modport master (
    output start, cont, ch_mask, cmp,
    input  dac_n, ch_sel, sample, busy, data, data_ch, done
  );

endinterface

// File: rtl/sar_core.sv
// sar_core: one successive-approximation conversion, MSB first.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_conv  : pulse; the next SIZE cycles form one conversion
//   cmp         : comparator, sampled every conversion cycle
//   trial       : current trial word, zero whenever no conversion runs
//   conv_done   : high during the last conversion cycle
//   result      : final code, valid from the cycle after conv_done
module sar_core
  import sar_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_conv,
  input  logic            cmp,
  output logic [SIZE-1:0] trial,
  output logic            conv_done,
  output logic [SIZE-1:0] result
);

  localparam int BW = clog2_min1(SIZE);

  logic            r_active;
  logic [BW-1:0]   r_bit;
  logic [SIZE-1:0] r_trial;
  logic [SIZE-1:0] r_result;
  logic [SIZE-1:0] w_trial_nxt;

  // Decide the bit under test from cmp and raise the next lower trial bit.
  // NOTE: w_trial_nxt gets a full default before the conditional writes, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_trial_nxt        = r_trial;
    w_trial_nxt[r_bit] = cmp;
    if (r_bit != '0) w_trial_nxt[r_bit - BW'(1)] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_bit    <= '0;
      r_trial  <= '0;
      r_result <= '0;
    end else if (start_conv) begin
      r_active <= 1'b1;
      r_bit    <= BW'(SIZE - 1);
      r_trial  <= {1'b1, {(SIZE-1){1'b0}}};
    end else if (r_active) begin
      if (r_bit == '0) begin
        // Last decision: keep the code, return the DAC to all-zero trial.
        r_result <= w_trial_nxt;
        r_trial  <= '0;
        r_active <= 1'b0;
      end else begin
        r_trial <= w_trial_nxt;
        r_bit   <= r_bit - BW'(1);
      end
    end
  end

  assign trial     = r_trial;
  assign conv_done = r_active && (r_bit == '0);
  assign result    = r_result;

endmodule

// File: rtl/sar_seq_mc.sv
// sar_seq_mc: multi-channel SAR ADC sequencer with result averaging.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sar_seq_mc_if.slave (scan control, comparator, DAC word,
//                mux select, S/H enable, busy, averaged result, done pulse)
// Each enabled channel is sampled SAMPLE_CYC clocks, converted in SIZE
// clocks, accumulated; after 2^AVG_LOG2 conversions the mean is published
// with a one-clock done pulse, then the scan moves to the next channel.
module sar_seq_mc
  import sar_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int NCH        = 4,
  parameter int AVG_LOG2   = 0,
  parameter int SAMPLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_seq_mc_if.slave bus
);

  localparam int CHW  = clog2_min1(NCH);
  localparam int SCW  = clog2_min1(SAMPLE_CYC);
  localparam int ACCW = SIZE + AVG_LOG2;
  localparam int AVW  = AVG_LOG2 + 1;

  sar_state_e      r_state;
  logic [SCW-1:0]  r_sample_cnt;
  logic [AVW-1:0]  r_avg_cnt;
  logic [ACCW-1:0] r_acc;
  logic [SIZE-1:0] r_data;
  logic [CHW-1:0]  r_data_ch;
  logic [CHW-1:0]  r_ch_sel;
  logic [NCH-1:0]  r_scan_mask;
  logic            r_sample;
  logic            r_busy;
  logic            r_done;

  logic [SIZE-1:0] w_trial;
  logic [SIZE-1:0] w_result;
  logic            w_conv_done;
  logic            w_start_conv;
  logic            w_mask_any;
  logic [CHW-1:0]  w_lo_in;
  logic            w_hi_ok;
  logic [CHW-1:0]  w_hi_ch;
  logic [ACCW-1:0] w_acc_sum;
  logic            w_last_conv;

  sar_core #(.SIZE(SIZE)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_conv (w_start_conv),
    .cmp        (bus.cmp),
    .trial      (w_trial),
    .conv_done  (w_conv_done),
    .result     (w_result)
  );

  // Channel search: lowest set bit of the live mask (scan start / wrap) and
  // the next set bit of the latched mask above the current channel. Both
  // loops run downward so the lowest qualifying index is written last.
  always_comb begin
    w_lo_in = '0;
    w_hi_ok = 1'b0;
    w_hi_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) w_lo_in = CHW'(i);
      if (r_scan_mask[i] && (i > int'(r_ch_sel))) begin
        w_hi_ok = 1'b1;
        w_hi_ch = CHW'(i);
      end
    end
  end

  assign w_mask_any   = |bus.ch_mask;
  // Raised in the last hold cycle so the core shows the MSB trial on the
  // first CONV cycle.
  assign w_start_conv = (r_state == ST_SAMPLE) && (r_sample_cnt == SCW'(SAMPLE_CYC - 1));
  assign w_acc_sum    = r_acc + ACCW'(w_result);
  assign w_last_conv  = (r_avg_cnt == AVW'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_avg_cnt    <= '0;
      r_acc        <= '0;
      r_data       <= '0;
      r_data_ch    <= '0;
      r_ch_sel     <= '0;
      r_scan_mask  <= '0;
      r_sample     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && w_mask_any) begin
            r_scan_mask  <= bus.ch_mask;
            r_ch_sel     <= w_lo_in;
            r_sample_cnt <= '0;
            r_sample     <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_start_conv) begin
            r_sample <= 1'b0;
            r_state  <= ST_CONV;
          end else begin
            r_sample_cnt <= r_sample_cnt + SCW'(1);
          end
        end
        ST_CONV: begin
          if (w_conv_done) r_state <= ST_ACC;
        end
        ST_ACC: begin
          if (w_last_conv) begin
            // Divide by 2^AVG_LOG2 by dropping the low accumulator bits.
            r_data    <= w_acc_sum[ACCW-1:AVG_LOG2];
            r_data_ch <= r_ch_sel;
            r_done    <= 1'b1;
            r_acc     <= '0;
            r_avg_cnt <= '0;
            r_state   <= ST_NEXT;
          end else begin
            r_acc        <= w_acc_sum;
            r_avg_cnt    <= r_avg_cnt + AVW'(1);
            r_sample_cnt <= '0;
            r_sample     <= 1'b1;
            r_state      <= ST_SAMPLE;
          end
        end
        ST_NEXT: begin
          if (w_hi_ok) begin
            r_ch_sel     <= w_hi_ch;
            r_sample_cnt <= '0;
            r_sample     <= 1'b1;
            r_state      <= ST_SAMPLE;
          end else if (bus.cont && w_mask_any) begin
            // Wrap: the live mask is re-latched here, so mask edits made
            // during a scan apply from this point on.
            r_scan_mask  <= bus.ch_mask;
            r_ch_sel     <= w_lo_in;
            r_sample_cnt <= '0;
            r_sample     <= 1'b1;
            r_state      <= ST_SAMPLE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dac_n   = ~w_trial;
  assign bus.ch_sel  = r_ch_sel;
  assign bus.sample  = r_sample;
  assign bus.busy    = r_busy;
  assign bus.data    = r_data;
  assign bus.data_ch = r_data_ch;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_sar_seq_mc.sv
// tb_sar_seq_mc: self-checking bench for sar_seq_mc.
// dut_a: SIZE=8, NCH=4, no averaging.  dut_b: SIZE=8, NCH=4, AVG_LOG2=2.
// Both use SAMPLE_CYC=2 and a 1.8 V full-scale comparator model; voltages
// are integer microvolts so every threshold decision is exact.
module tb_sar_seq_mc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  sar_seq_mc_if #(.SIZE(8), .NCH(4)) ifa ();
  sar_seq_mc_if #(.SIZE(8), .NCH(4)) ifb ();

  sar_seq_mc #(.SIZE(8), .NCH(4), .AVG_LOG2(0), .SAMPLE_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  sar_seq_mc #(.SIZE(8), .NCH(4), .AVG_LOG2(2), .SAMPLE_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  // Analog side: per-channel input for dut_a; per-conversion input for dut_b
  // (b_conv counts S/H openings so the averaged conversions can differ).
  longint      ain_a [4];
  longint      ain_b [4];
  int unsigned b_conv = 0;
  int unsigned b_base = 0;
  logic        b_sample_d = 1'b0;
  logic [7:0]  code_a, code_b;

  assign code_a  = ~ifa.dac_n;
  assign code_b  = ~ifb.dac_n;
  assign ifa.cmp = (ain_a[ifa.ch_sel] * 256) > (longint'(code_a) * 1800000);
  assign ifb.cmp = (ain_b[(b_conv - b_base + 3) % 4] * 256) > (longint'(code_b) * 1800000);

  always @(posedge clk) begin
    b_sample_d <= ifb.sample;
    if (ifb.sample && !b_sample_d) b_conv <= b_conv + 1;
  end

  // Ideal converter: largest code whose DAC level is strictly below Ain.
  function automatic longint sar_code(input longint uv);
    longint c;
    if (uv <= 0) return 0;
    c = (uv * 256 - 1) / 1800000;
    if (c > 255) c = 255;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for the S/H window to open on DUT sel (0=a, 1=b), then drop start.
  task automatic wait_sample(input bit sel, output int c0);
    c0 = -1;
    for (int i = 0; i < 8 && c0 < 0; i++) begin
      @(negedge clk);
      if (sel ? ifb.sample : ifa.sample) c0 = cyc;
    end
    if (sel) ifb.start = 1'b0; else ifa.start = 1'b0;
    check("sample_seen", c0 >= 0, 1);
  endtask

  // Wait for done on DUT sel; also counts sample-high cycles on the way.
  task automatic wait_done(input bit sel, input int budget, output int c, output int n_samp);
    c = -1;
    n_samp = 0;
    for (int i = 0; i < budget && c < 0; i++) begin
      @(negedge clk);
      if (sel ? ifb.sample : ifa.sample) n_samp++;
      if (sel ? ifb.done : ifa.done) c = cyc;
    end
    check("done_seen", c >= 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, cp, ns, nd, nb;
    logic [3:0] m;
    int exp_q[$];
    longint sum;

    ifa.start = 1'b0; ifa.cont = 1'b0; ifa.ch_mask = '0;
    ifb.start = 1'b0; ifb.cont = 1'b0; ifb.ch_mask = '0;
    for (int i = 0; i < 4; i++) begin ain_a[i] = 0; ain_b[i] = 0; end

    // ---------------- reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dac_n",   ifa.dac_n,   8'hFF);
    check("rst_busy",    ifa.busy,    0);
    check("rst_sample",  ifa.sample,  0);
    check("rst_done",    ifa.done,    0);
    check("rst_data",    ifa.data,    0);
    check("rst_data_ch", ifa.data_ch, 0);
    check("rst_ch_sel",  ifa.ch_sel,  0);
    check("rst_b_dac_n", ifb.dac_n,   8'hFF);
    check("rst_b_busy",  ifb.busy,    0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- single conversion, 0.24 V -> 34, 11 clocks
    ain_a[0] = 240000;
    ifa.ch_mask = 4'b0001; ifa.cont = 1'b0; ifa.start = 1'b1;
    wait_sample(0, c0);
    check("s_dac_idle", ifa.dac_n, 8'hFF);
    check("s_busy",     ifa.busy,  1);
    wait_done(0, 40, c1, ns);
    check("s_latency", c1 - c0, 11);
    check("s_data",    ifa.data, 34);
    check("s_data_ch", ifa.data_ch, 0);
    check("s_sample_len", ns + 1, 2);
    @(negedge clk);
    check("s_done_one_clk", ifa.done, 0);
    check("s_idle_busy",    ifa.busy, 0);

    // ---------------- input sweep on channel 0
    for (int k = 0; k < 67; k++) begin
      ain_a[0] = 263200 + 23200 * k;
      ifa.start = 1'b1;
      wait_sample(0, c0);
      wait_done(0, 40, c1, ns);
      check("sweep_data", ifa.data, sar_code(ain_a[0]));
      @(negedge clk);
    end

    // ---------------- two-channel scan 1010; a start pulse mid-scan is ignored
    ain_a[1] = 500000; ain_a[3] = 1000000;
    ifa.ch_mask = 4'b1010; ifa.start = 1'b1;
    wait_sample(0, c0);
    check("m_first_ch", ifa.ch_sel, 1);
    wait_done(0, 40, c1, ns);
    check("m_ch1",   ifa.data_ch, 1);
    check("m_data1", ifa.data, 71);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done(0, 40, c1, ns);
    check("m_ch3",   ifa.data_ch, 3);
    check("m_data3", ifa.data, 142);
    @(negedge clk);
    check("m_busy_drop", ifa.busy, 0);

    // ---------------- random scans against the scoreboard
    for (int t = 0; t < 6; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) ain_a[i] = longint'($urandom_range(1, 1799999));
      exp_q.delete();
      for (int i = 0; i < 4; i++) if (m[i]) exp_q.push_back(i);
      ifa.ch_mask = m; ifa.start = 1'b1;
      wait_sample(0, c0);
      check("r_first_ch", ifa.ch_sel, exp_q[0]);
      foreach (exp_q[j]) begin
        wait_done(0, 40, c1, ns);
        check("r_data_ch", ifa.data_ch, exp_q[j]);
        check("r_data",    ifa.data, sar_code(ain_a[exp_q[j]]));
      end
      @(negedge clk);
      check("r_busy_drop", ifa.busy, 0);
    end

    // ---------------- continuous mode, one channel: period 12
    ain_a[0] = 910000;
    ifa.ch_mask = 4'b0001; ifa.cont = 1'b1; ifa.start = 1'b1;
    wait_sample(0, c0);
    wait_done(0, 40, cp, ns);
    for (int r = 0; r < 3; r++) begin
      wait_done(0, 40, c1, ns);
      check("c_period", c1 - cp, 12);
      check("c_data",   ifa.data, sar_code(910000));
      cp = c1;
    end
    repeat (3) @(negedge clk);
    ifa.cont = 1'b0;
    wait_done(0, 40, c1, ns);
    check("c_last_period", c1 - cp, 12);
    @(negedge clk);
    check("c_busy_drop", ifa.busy, 0);
    nd = 0;
    repeat (30) begin @(negedge clk); if (ifa.done) nd++; end
    check("c_no_more_done", nd, 0);

    // ---------------- mask edits apply only at the wrap
    ain_a[0] = 300000; ain_a[1] = 600000; ain_a[2] = 1200000;
    ifa.ch_mask = 4'b0011; ifa.cont = 1'b1; ifa.start = 1'b1;
    wait_sample(0, c0);
    wait_done(0, 40, c1, ns);
    check("w_ch0", ifa.data_ch, 0);
    ifa.ch_mask = 4'b0100;
    wait_done(0, 40, c1, ns);
    check("w_ch1_latched", ifa.data_ch, 1);
    check("w_data1", ifa.data, sar_code(600000));
    wait_done(0, 40, c1, ns);
    check("w_ch2_wrap", ifa.data_ch, 2);
    check("w_data2", ifa.data, sar_code(1200000));
    ifa.cont = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w_busy_drop", ifa.busy, 0);

    // ---------------- averaging: codes 100/101 alternating -> 100
    b_base = b_conv;
    ain_b[0] = 706700; ain_b[1] = 713700; ain_b[2] = 706700; ain_b[3] = 713700;
    ifb.ch_mask = 4'b0001; ifb.cont = 1'b0; ifb.start = 1'b1;
    wait_sample(1, c0);
    wait_done(1, 100, c1, ns);
    check("a_latency", c1 - c0, 44);
    check("a_data",    ifb.data, 100);
    check("a_sample_cycles", ns + 1, 8);
    nd = 0;
    repeat (20) begin @(negedge clk); if (ifb.done) nd++; end
    check("a_single_done", nd, 0);
    check("a_busy_drop", ifb.busy, 0);

    for (int t = 0; t < 3; t++) begin
      b_base = b_conv;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        ain_b[i] = longint'($urandom_range(1, 1799999));
        sum += sar_code(ain_b[i]);
      end
      ifb.start = 1'b1;
      wait_sample(1, c0);
      wait_done(1, 100, c1, ns);
      check("ar_data", ifb.data, sum / 4);
      check("ar_data_ch", ifb.data_ch, 0);
      @(negedge clk);
    end

    // ---------------- reset in CONV cycle 3 aborts at once
    ain_a[0] = 1000000;
    ifa.ch_mask = 4'b0001; ifa.cont = 1'b0; ifa.start = 1'b1;
    wait_sample(0, c0);
    repeat (5) @(negedge clk);
    check("x_in_conv", ifa.dac_n != 8'hFF, 1);
    #2 rst_n = 1'b0;
    #1;
    check("x_dac_n",  ifa.dac_n,  8'hFF);
    check("x_busy",   ifa.busy,   0);
    check("x_sample", ifa.sample, 0);
    check("x_ch_sel", ifa.ch_sel, 0);
    nd = 0;
    repeat (3) begin @(negedge clk); if (ifa.done) nd++; end
    rst_n = 1'b1;
    nb = 0;
    repeat (20) begin @(negedge clk); if (ifa.done) nd++; if (ifa.busy) nb++; end
    check("x_no_done", nd, 0);
    check("x_stays_idle", nb, 0);

    // ---------------- start with an empty mask is ignored
    ifa.ch_mask = 4'b0000; ifa.start = 1'b1;
    nb = 0;
    repeat (6) begin @(negedge clk); if (ifa.busy) nb++; end
    ifa.start = 1'b0;
    check("z_empty_mask", nb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
